// File: rtl/dac_sweep_ctrl.sv
// Frequency-sweep scheduler for one DAC channel: steps the DDS phase
// increment from start to stop, settling, measuring and reporting each point.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, abort      : sweep control pulses (abort wins)
//   idle_step         : DDS step passed through while idle
//   start/stop/incr   : sweep limits and increment, latched on start
//   settle/dwell      : per-point wait and measurement lengths, latched
//   dds_step          : registered step to the DDS
//   stat_cfg          : sigstat control, bit0 = clear, bit1 = enable
//   stat_min/max      : sigstat results
//   res_*             : per-point result, valid/ready handshake
//   busy, done        : sweep in progress, 1-cycle end-of-sweep pulse
module dac_sweep_ctrl #(
  parameter int STEP_W = 32,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] idle_step,
  input  logic [STEP_W-1:0] start_step,
  input  logic [STEP_W-1:0] stop_step,
  input  logic [STEP_W-1:0] incr_step,
  input  logic [CNT_W-1:0]  settle_cycles,
  input  logic [CNT_W-1:0]  dwell_cycles,
  output logic [STEP_W-1:0] dds_step,
  output logic [1:0]        stat_cfg,
  input  logic [DATA_W-1:0] stat_min,
  input  logic [DATA_W-1:0] stat_max,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [STEP_W-1:0] res_step,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_max,
  output logic [IDX_W-1:0]  res_index,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CLEAR,
    S_MEASURE,
    S_CAPTURE,
    S_REPORT,
    S_NEXT
  } state_t;

  state_t state;

  logic [STEP_W-1:0] stop_q;
  logic [STEP_W-1:0] incr_q;
  logic [CNT_W-1:0]  settle_q;
  logic [CNT_W-1:0]  dwell_q;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;

  // One extra bit catches wrap past the top of the step range.
  logic [STEP_W:0] sum;
  logic            last_pt;

  assign sum = {1'b0, dds_step} + {1'b0, incr_q};
  assign last_pt = (incr_q == '0) || sum[STEP_W] ||
                   (sum[STEP_W-1:0] > stop_q);

  // stat_cfg is registered, so it is loaded on entry to each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      dds_step  <= '0;
      stat_cfg  <= 2'b00;
      res_valid <= 1'b0;
      res_step  <= '0;
      res_min   <= '0;
      res_max   <= '0;
      res_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stop_q    <= '0;
      incr_q    <= '0;
      settle_q  <= '0;
      dwell_q   <= '0;
      cnt       <= '0;
      idx       <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state     <= S_IDLE;
        stat_cfg  <= 2'b00;
        res_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            dds_step <= idle_step;
            if (start && !abort) begin
              stop_q   <= stop_step;
              incr_q   <= incr_step;
              settle_q <= settle_cycles;
              dwell_q  <= dwell_cycles;
              dds_step <= start_step;
              idx      <= '0;
              cnt      <= settle_cycles;
              busy     <= 1'b1;
              state    <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (cnt == '0) begin
              stat_cfg <= 2'b01;
              state    <= S_CLEAR;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_CLEAR: begin
            // Zero dwell still gives one enable cycle.
            cnt      <= (dwell_q == '0) ? '0 : dwell_q - CNT_W'(1);
            stat_cfg <= 2'b10;
            state    <= S_MEASURE;
          end
          S_MEASURE: begin
            if (cnt == '0) begin
              stat_cfg <= 2'b00;
              state    <= S_CAPTURE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_CAPTURE: begin
            res_min   <= stat_min;
            res_max   <= stat_max;
            res_step  <= dds_step;
            res_index <= idx;
            res_valid <= 1'b1;
            state     <= S_REPORT;
          end
          S_REPORT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              state     <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (last_pt) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              dds_step <= sum[STEP_W-1:0];
              idx      <= idx + IDX_W'(1);
              cnt      <= settle_q;
              state    <= S_SETTLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// Testbench for dac_sweep_ctrl: table of whole sweeps plus directed
// sequences for timing, backpressure, abort, reset and ignored starts.
module tb_dac_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] idle_step = '0;
  logic [31:0] start_step = '0;
  logic [31:0] stop_step = '0;
  logic [31:0] incr_step = '0;
  logic [31:0] settle_cycles = '0;
  logic [31:0] dwell_cycles = '0;
  logic [31:0] dds_step;
  logic [1:0]  stat_cfg;
  logic [7:0]  stat_min;
  logic [7:0]  stat_max;
  logic        res_valid;
  logic        ready = 1'b1;
  logic [31:0] res_step;
  logic [7:0]  res_min;
  logic [7:0]  res_max;
  logic [15:0] res_index;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // sigstat stand-in: results derived from the step being measured
  assign stat_min = dds_step[7:0] ^ 8'h5A;
  assign stat_max = dds_step[7:0] + 8'd3;

  dac_sweep_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .idle_step(idle_step), .start_step(start_step),
    .stop_step(stop_step), .incr_step(incr_step),
    .settle_cycles(settle_cycles), .dwell_cycles(dwell_cycles),
    .dds_step(dds_step), .stat_cfg(stat_cfg),
    .stat_min(stat_min), .stat_max(stat_max),
    .res_valid(res_valid), .res_ready(ready),
    .res_step(res_step), .res_min(res_min), .res_max(res_max),
    .res_index(res_index), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic [31:0] inc;
    logic [31:0] set;
    logic [31:0] dw;
    int          npts;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    start_step    = v.s;
    stop_step     = v.e;
    incr_step     = v.inc;
    settle_cycles = v.set;
    dwell_cycles  = v.dw;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_point(input string nm, input vec_t v, input int i);
    logic [31:0] es;
    es = v.s + 32'(i) * v.inc;
    chk({nm, " step"}, 64'(res_step), 64'(es));
    chk({nm, " index"}, 64'(res_index), 64'(i));
    chk({nm, " min"}, 64'(res_min), 64'(es[7:0] ^ 8'h5A));
    chk({nm, " max"}, 64'(res_max), 64'(es[7:0] + 8'd3));
  endtask

  task automatic run_sweep(input vec_t v, input int k);
    int  got;
    bit  fin;
    string nm;
    nm = $sformatf("tbl%0d", k);
    ready = 1'b1;
    idle_step = 32'hCAFE_0000 + 32'(k);
    load(v);
    pulse_start();
    got = 0;
    fin = 1'b0;
    for (int c = 0; c < 5000 && !fin; c++) begin
      if (res_valid) begin
        chk_point(nm, v, got);
        got++;
      end
      if (done) fin = 1'b1;
      else tick();
    end
    if (!fin) chk({nm, " done timeout"}, 64'(0), 64'(1));
    chk({nm, " points"}, 64'(got), 64'(v.npts));
    tick();
    chk({nm, " idle passthru"}, 64'(dds_step), 64'(idle_step));
    chk({nm, " busy after"}, 64'(busy), 64'(0));
  endtask

  task automatic wait_cfg(input logic [1:0] want, input string nm);
    int c;
    c = 0;
    while (stat_cfg != want && c < 200) begin
      tick();
      c++;
    end
    if (c >= 200) chk({nm, " wait timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    logic [1:0]  exp_cfg[10];
    logic [1:0]  got_cfg[10];
    logic        got_val[10];
    vec_t        v;
    int          got;
    int          en_cyc;
    bit          fin;
    bit          ok;

    tbl[0] = '{32'd100, 32'd130, 32'd10, 32'd2, 32'd4, 4};
    tbl[1] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 32'd1, 32'd2, 1};
    tbl[2] = '{32'd5, 32'd100, 32'd0, 32'd1, 32'd1, 1};
    tbl[3] = '{32'd50, 32'd50, 32'd7, 32'd0, 32'd0, 1};
    tbl[4] = '{32'd200, 32'd100, 32'd5, 32'd1, 32'd1, 1};
    tbl[5] = '{32'd0, 32'd25, 32'd10, 32'd0, 32'd1, 3};
    tbl[6] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd8, 32'd0, 32'd1, 2};

    exp_cfg = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                2'd0, 2'd0};

    // reset state
    idle_step = 32'h0000_1234;
    tick();
    tick();
    chk("rst dds_step", 64'(dds_step), 64'(0));
    chk("rst stat_cfg", 64'(stat_cfg), 64'(0));
    chk("rst res_valid", 64'(res_valid), 64'(0));
    chk("rst res_step", 64'(res_step), 64'(0));
    chk("rst res_index", 64'(res_index), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    reset = 1'b0;
    tick();
    chk("idle passthru", 64'(dds_step), 64'(32'h1234));

    for (int k = 0; k < 7; k++) run_sweep(tbl[k], k);

    // per-point timing, then backpressure at point 1
    v = tbl[0];
    load(v);
    ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      got_cfg[i] = stat_cfg;
      got_val[i] = res_valid;
      if (i < 9) tick();
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("timing cfg c%0d", i), 64'(got_cfg[i]),
          64'(exp_cfg[i]));
    end
    chk("timing valid c8", 64'(got_val[8]), 64'(0));
    chk("timing valid c9", 64'(got_val[9]), 64'(1));
    chk_point("bp p0", v, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    got = 0;
    while (!res_valid && got < 200) begin
      tick();
      got++;
    end
    if (got >= 200) chk("bp p1 timeout", 64'(0), 64'(1));
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (res_valid !== 1'b1 || res_step !== 32'd110 ||
          res_index !== 16'd1 || res_min !== (8'd110 ^ 8'h5A) ||
          res_max !== 8'd113 || dds_step !== 32'd110 ||
          stat_cfg !== 2'b00)
        ok = 1'b0;
      tick();
    end
    chk("bp hold stable", 64'(ok), 64'(1));
    chk_point("bp p1", v, 1);
    ready = 1'b1;
    got = 2;
    fin = 1'b0;
    tick();
    for (int c = 0; c < 500 && !fin; c++) begin
      if (res_valid) begin
        chk_point("bp rest", v, got);
        got++;
      end
      if (done) fin = 1'b1;
      else tick();
    end
    chk("bp done seen", 64'(fin), 64'(1));
    chk("bp points", 64'(got), 64'(4));

    // abort during MEASURE
    idle_step = 32'h0000_0ABC;
    v = '{32'd7, 32'd1000, 32'd1, 32'd1, 32'd10, 0};
    load(v);
    pulse_start();
    wait_cfg(2'b10, "abort");
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort cfg", 64'(stat_cfg), 64'(0));
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort valid", 64'(res_valid), 64'(0));
    ok = 1'b1;
    if (done) ok = 1'b0;
    tick();
    chk("abort idle step", 64'(dds_step), 64'(32'hABC));
    for (int i = 0; i < 5; i++) begin
      if (done || busy) ok = 1'b0;
      tick();
    end
    chk("abort no done", 64'(ok), 64'(1));

    // start + abort together in IDLE does nothing
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start+abort busy", 64'(busy), 64'(0));
    tick();
    chk("start+abort step", 64'(dds_step), 64'(32'hABC));

    // second start after abort still sweeps
    run_sweep(tbl[5], 7);

    // zero settle/dwell, start while busy ignored
    v = tbl[3];
    load(v);
    pulse_start();
    got = 0;
    en_cyc = 0;
    fin = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (c == 1) begin
        start_step = 32'd999;
        stop_step  = 32'd5000;
        start = 1'b1;
      end
      if (c == 2) start = 1'b0;
      if (stat_cfg == 2'b10) en_cyc++;
      if (res_valid) begin
        chk_point("busy start", v, got);
        got++;
      end
      if (done) fin = 1'b1;
      else tick();
    end
    start = 1'b0;
    chk("dwell0 enable cycles", 64'(en_cyc), 64'(1));
    chk("busy start points", 64'(got), 64'(1));
    chk("busy start done", 64'(fin), 64'(1));
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) ok = 1'b0;
    end
    chk("busy start no restart", 64'(ok), 64'(1));

    // reset mid-sweep
    idle_step = 32'h0000_0777;
    load(tbl[0]);
    pulse_start();
    wait_cfg(2'b10, "midrst");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst dds_step", 64'(dds_step), 64'(0));
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst cfg", 64'(stat_cfg), 64'(0));
    chk("midrst res_step", 64'(res_step), 64'(0));
    tick();
    chk("midrst passthru", 64'(dds_step), 64'(32'h777));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
